// File: rtl/trellis_neighbor_checker_seq.sv
// Sequencer/config controller for the trellis neighbor checker: error window, pattern double-buffer, result capture, event counter.
// Optional energy-threshold flag suppression is enabled by defining TNC_SEQ_ENER_THRESH_EN.

module trellis_neighbor_checker_seq_lane #(
  parameter int flag_bitwidth = 4
`ifdef TNC_SEQ_ENER_THRESH_EN
  , parameter int ener_bitwidth = 18
`endif
) (
  input  logic [flag_bitwidth-1:0] flag_i,
`ifdef TNC_SEQ_ENER_THRESH_EN
  input  logic [ener_bitwidth-1:0] ener_i,
  input  logic [ener_bitwidth-1:0] thresh_i,
`endif
  output logic [flag_bitwidth-1:0] flag_o,
  output logic                     nz_o
);

`ifdef TNC_SEQ_ENER_THRESH_EN
  // High-energy candidates are not trusted: drop the flag entirely.
  assign flag_o = (ener_i >= thresh_i) ? '0 : flag_i;
`else
  assign flag_o = flag_i;
`endif
  assign nz_o = |flag_o;

endmodule

module trellis_neighbor_checker_seq #(
  parameter int width                   = 16,
  parameter int est_err_bitwidth        = 9,
  parameter int branch_bitwidth         = 2,
  parameter int num_of_trellis_patterns = 4,
  parameter int trellis_pattern_depth   = 4,
  parameter int ener_bitwidth           = 18,
  parameter int flag_bitwidth           = 4,
  parameter int cnt_bitwidth            = 16,
  localparam int NPAT   = num_of_trellis_patterns * trellis_pattern_depth,
  localparam int ADDR_W = $clog2(NPAT),
  localparam int WORD_W = width * est_err_bitwidth
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WORD_W-1:0]                 err_in,
  input  logic                              err_in_valid,
  output logic [2*WORD_W-1:0]               errstream_out,
  output logic                              chk_valid,
  input  logic [width*flag_bitwidth-1:0]    chk_flags,
  input  logic [width*ener_bitwidth-1:0]    chk_eners,
  output logic [width*flag_bitwidth-1:0]    flags_out,
  output logic [width*ener_bitwidth-1:0]    eners_out,
  output logic                              flags_valid,
  input  logic                              cfg_wr_en,
  input  logic [ADDR_W-1:0]                 cfg_addr,
  input  logic [branch_bitwidth-1:0]        cfg_data,
  input  logic                              cfg_commit,
  output logic                              cfg_busy,
  output logic [NPAT*branch_bitwidth-1:0]   patterns_out,
`ifdef TNC_SEQ_ENER_THRESH_EN
  input  logic [ener_bitwidth-1:0]          ener_thresh,
`endif
  input  logic                              cnt_clear,
  output logic [cnt_bitwidth-1:0]           err_event_count
);

  localparam int POP_W = $clog2(width + 1);
  localparam int CW1   = cnt_bitwidth + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_HALF, ST_FULL} state_t;

  state_t                                   state_q, state_d;
  logic [WORD_W-1:0]                        prev_q, prev_d, cur_q, cur_d;
  logic                                     chk_valid_q, chk_valid_d;
  logic                                     flags_valid_q, flags_valid_d;
  logic [width-1:0][flag_bitwidth-1:0]      flags_q, flags_d;
  logic [width*ener_bitwidth-1:0]           eners_q, eners_d;
  logic [cnt_bitwidth-1:0]                  cnt_q, cnt_d;
  logic                                     pending_q, pending_d;
  logic [NPAT-1:0][branch_bitwidth-1:0]     shadow_q, shadow_d;
  logic [NPAT-1:0][branch_bitwidth-1:0]     active_q, active_d;

  logic [width-1:0][flag_bitwidth-1:0]      flags_in, flags_m;
  logic [width-1:0]                         nz;
  logic [POP_W-1:0]                         pop;
  logic [CW1-1:0]                           cnt_sum;
  logic                                     addr_ok, wr_ok, apply;

  assign flags_in = chk_flags;

  for (genvar l = 0; l < width; l++) begin : g_lane
    trellis_neighbor_checker_seq_lane #(
      .flag_bitwidth(flag_bitwidth)
`ifdef TNC_SEQ_ENER_THRESH_EN
      , .ener_bitwidth(ener_bitwidth)
`endif
    ) u_lane (
      .flag_i   (flags_in[l]),
`ifdef TNC_SEQ_ENER_THRESH_EN
      .ener_i   (chk_eners[l*ener_bitwidth +: ener_bitwidth]),
      .thresh_i (ener_thresh),
`endif
      .flag_o   (flags_m[l]),
      .nz_o     (nz[l])
    );
  end

  // Only non-power-of-two pattern tables can see an out-of-range address.
  if ((2 ** ADDR_W) > NPAT) begin : g_addr_chk
    assign addr_ok = (cfg_addr < ADDR_W'(NPAT));
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  assign wr_ok = cfg_wr_en & addr_ok & ~pending_q;
  assign apply = pending_q & ~chk_valid_q & ~err_in_valid;

  always_comb begin
    pop = '0;
    for (int l = 0; l < width; l++) pop = pop + POP_W'(nz[l]);
    cnt_sum = {1'b0, cnt_q} + CW1'(pop);
  end

  always_comb begin
    state_d       = state_q;
    chk_valid_d   = 1'b0;
    prev_d        = prev_q;
    cur_d         = cur_q;
    flags_d       = flags_q;
    eners_d       = eners_q;
    flags_valid_d = chk_valid_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q ? ~apply : cfg_commit;

    case (state_q)
      ST_EMPTY: if (err_in_valid) state_d = ST_HALF;
      ST_HALF: begin
        if (err_in_valid) begin
          state_d     = ST_FULL;
          chk_valid_d = 1'b1;
        end
      end
      ST_FULL:  chk_valid_d = err_in_valid;
      default:  state_d = ST_EMPTY;
    endcase

    if (err_in_valid) begin
      prev_d = cur_q;
      cur_d  = err_in;
    end

    if (chk_valid_q) begin
      flags_d = flags_m;
      eners_d = chk_eners;
    end

    if (cnt_clear)
      cnt_d = '0;
    else if (chk_valid_q)
      cnt_d = cnt_sum[cnt_bitwidth] ? '1 : cnt_sum[cnt_bitwidth-1:0];

    // Writes are blocked while pending, so the copy always sees a settled shadow.
    if (wr_ok) shadow_d[cfg_addr] = cfg_data;
    if (apply) active_d = shadow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      prev_q        <= '0;
      cur_q         <= '0;
      chk_valid_q   <= 1'b0;
      flags_valid_q <= 1'b0;
      flags_q       <= '0;
      eners_q       <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      cur_q         <= cur_d;
      chk_valid_q   <= chk_valid_d;
      flags_valid_q <= flags_valid_d;
      flags_q       <= flags_d;
      eners_q       <= eners_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign errstream_out   = {cur_q, prev_q};
  assign chk_valid       = chk_valid_q;
  assign flags_out       = flags_q;
  assign eners_out       = eners_q;
  assign flags_valid     = flags_valid_q;
  assign cfg_busy        = pending_q;
  assign patterns_out    = active_q;
  assign err_event_count = cnt_q;

endmodule

// File: tb/tb_trellis_neighbor_checker_seq.sv
// Randomized self-checking bench for trellis_neighbor_checker_seq against a transaction-level model.
module tb_trellis_neighbor_checker_seq;
  localparam int W = 16, EW = 9, FW = 4, NW = 18, NPAT = 16, BB = 2;
  localparam int WW = W * EW;

  logic clk = 1'b0;
  logic rst;
  logic [WW-1:0] err_in;
  logic err_in_valid;
  logic [2*WW-1:0] errstream_out;
  logic chk_valid;
  logic [W*FW-1:0] chk_flags;
  logic [W*NW-1:0] chk_eners;
  logic [W*FW-1:0] flags_out;
  logic [W*NW-1:0] eners_out;
  logic flags_valid, cfg_wr_en, cfg_commit, cfg_busy, cnt_clear;
  logic [3:0] cfg_addr;
  logic [BB-1:0] cfg_data;
  logic [NPAT*BB-1:0] patterns_out;
  logic [15:0] err_event_count;
`ifdef TNC_SEQ_ENER_THRESH_EN
  logic [NW-1:0] ener_thresh;
`endif

  int n_checks = 0, n_fail = 0;

  // Model state
  int m_words, m_cnt;
  logic [WW-1:0] m_prev, m_cur;
  logic m_chk, m_fv, m_pend;
  logic [W*FW-1:0] m_flags;
  logic [W*NW-1:0] m_eners;
  logic [BB-1:0] m_shadow[NPAT], m_active[NPAT];

  trellis_neighbor_checker_seq dut (
    .clk(clk), .rst(rst), .err_in(err_in), .err_in_valid(err_in_valid),
    .errstream_out(errstream_out), .chk_valid(chk_valid),
    .chk_flags(chk_flags), .chk_eners(chk_eners),
    .flags_out(flags_out), .eners_out(eners_out), .flags_valid(flags_valid),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .patterns_out(patterns_out),
`ifdef TNC_SEQ_ENER_THRESH_EN
    .ener_thresh(ener_thresh),
`endif
    .cnt_clear(cnt_clear), .err_event_count(err_event_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] r;
    for (int i = 0; i < WW; i += 32) r[i +: 32] = WW'($urandom) ;
    return r;
  endfunction

  function automatic logic [W*FW-1:0] flags_nz(int n);
    logic [W*FW-1:0] r;
    r = '0;
    for (int i = 0; i < n && i < W; i++) r[i*FW +: FW] = FW'($urandom_range(1, 15));
    return r;
  endfunction

  function automatic logic [W*NW-1:0] rand_eners();
    logic [W*NW-1:0] r;
    for (int i = 0; i < W; i++) r[i*NW +: NW] = NW'($urandom_range(0, 300));
    return r;
  endfunction

  function automatic logic [NPAT*BB-1:0] pack_active();
    logic [NPAT*BB-1:0] r;
    for (int i = 0; i < NPAT; i++) r[i*BB +: BB] = m_active[i];
    return r;
  endfunction

  task automatic idle();
    err_in_valid = 0; cfg_wr_en = 0; cfg_commit = 0; cnt_clear = 0;
  endtask

  // Advance one clock: the model absorbs the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_words = 0; m_cnt = 0; m_prev = '0; m_cur = '0; m_chk = 0; m_fv = 0;
      m_pend = 0; m_flags = '0; m_eners = '0;
      for (int i = 0; i < NPAT; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    end else begin
      logic [W*FW-1:0] mf;
      logic [FW-1:0] f;
      int nzc;
      logic app;
      mf = '0; nzc = 0;
      for (int l = 0; l < W; l++) begin
        f = chk_flags[l*FW +: FW];
`ifdef TNC_SEQ_ENER_THRESH_EN
        if (chk_eners[l*NW +: NW] >= ener_thresh) f = '0;
`endif
        if (f != 0) nzc++;
        mf[l*FW +: FW] = f;
      end
      app = m_pend && !m_chk && !err_in_valid;
      if (cfg_wr_en && !m_pend) m_shadow[cfg_addr] = cfg_data;
      if (app) for (int i = 0; i < NPAT; i++) m_active[i] = m_shadow[i];
      m_pend = m_pend ? !app : cfg_commit;
      if (cnt_clear) m_cnt = 0;
      else if (m_chk) m_cnt = (m_cnt + nzc > 65535) ? 65535 : m_cnt + nzc;
      if (m_chk) begin m_flags = mf; m_eners = chk_eners; end
      m_fv = m_chk;
      m_chk = err_in_valid && (m_words > 0);
      if (err_in_valid) begin m_prev = m_cur; m_cur = err_in; m_words++; end
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    err_in_valid = 1; err_in = rand_word(); cfg_commit = 1; cnt_clear = 0;
    tick(); idle(); tick(); rst = 0;
    n_checks++;
    if ({chk_valid, flags_valid, cfg_busy, err_event_count} !== 19'd0) begin
      n_fail++; $display("FAIL reset_ctrl got %b/%b/%b/%0d want all 0", chk_valid, flags_valid, cfg_busy, err_event_count);
    end
    n_checks++;
    if (errstream_out !== '0 || flags_out !== '0 || eners_out !== '0) begin
      n_fail++; $display("FAIL reset_data got win=%h flags=%h want 0", errstream_out, flags_out);
    end
    n_checks++;
    if (patterns_out !== '0) begin
      n_fail++; $display("FAIL reset_patterns got %h want 0", patterns_out);
    end
  endtask

  task automatic test_stream_abc();
    logic [WW-1:0] w[3];
    int nchk;
    do_reset();
    nchk = 0;
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    for (int i = 0; i < 5; i++) begin
      err_in_valid = (i < 3); err_in = (i < 3) ? w[i] : '0;
      chk_flags = flags_nz($urandom_range(0, 16)); chk_eners = rand_eners();
      tick();
      nchk += chk_valid;
      n_checks++;
      if (chk_valid !== (i == 1 || i == 2) || flags_valid !== (i == 2 || i == 3)) begin
        n_fail++; $display("FAIL abc_valids cyc %0d got chk=%b fv=%b", i, chk_valid, flags_valid);
      end
      if (i == 1 || i == 2) begin
        n_checks++;
        if (errstream_out !== {w[i], w[i-1]}) begin
          n_fail++; $display("FAIL abc_window cyc %0d got %h want %h", i, errstream_out, {w[i], w[i-1]});
        end
      end
      n_checks++;
      if (flags_out !== m_flags || eners_out !== m_eners || err_event_count !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL abc_results cyc %0d got flags=%h cnt=%0d want flags=%h cnt=%0d", i, flags_out, err_event_count, m_flags, m_cnt);
      end
    end
    n_checks++;
    if (nchk != 2) begin n_fail++; $display("FAIL abc_chk_count got %0d want 2", nchk); end
  endtask

  task automatic test_sparse();
    int nchk, nfv;
    do_reset();
    nchk = 0; nfv = 0;
    for (int i = 0; i < 36; i++) begin
      idle();
      err_in_valid = (i % 3 == 0); err_in = rand_word();
      chk_flags = flags_nz($urandom_range(0, 16)); chk_eners = rand_eners();
      tick();
      nchk += chk_valid; nfv += flags_valid;
      n_checks++;
      if (chk_valid !== m_chk || flags_valid !== m_fv || errstream_out !== {m_cur, m_prev}) begin
        n_fail++; $display("FAIL sparse cyc %0d got chk=%b fv=%b win=%h want chk=%b fv=%b win=%h", i, chk_valid, flags_valid, errstream_out, m_chk, m_fv, {m_cur, m_prev});
      end
      n_checks++;
      if (flags_out !== m_flags || err_event_count !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL sparse_results cyc %0d got cnt=%0d want %0d", i, err_event_count, m_cnt);
      end
    end
    n_checks++;
    if (nchk != 11 || nfv != 11) begin n_fail++; $display("FAIL sparse_pulses got chk=%0d fv=%0d want 11/11", nchk, nfv); end
  endtask

  task automatic test_commit();
    do_reset();
    cfg_wr_en = 1; cfg_addr = 4'd9; cfg_data = 2'b11; tick(); idle();
    for (int i = 0; i < 14; i++) begin
      idle();
      err_in_valid = (i < 8); err_in = rand_word();
      chk_flags = '0; chk_eners = '0;
      if (i == 3) cfg_commit = 1;
      if (i == 5) begin cfg_wr_en = 1; cfg_addr = 4'd0; cfg_data = 2'b01; end
      tick();
      n_checks++;
      if (cfg_busy !== m_pend || patterns_out !== pack_active()) begin
        n_fail++; $display("FAIL commit cyc %0d got busy=%b pat=%h want busy=%b pat=%h", i, cfg_busy, patterns_out, m_pend, pack_active());
      end
      if (i >= 3 && i <= 8) begin
        n_checks++;
        if (cfg_busy !== 1'b1 || patterns_out !== 32'h0) begin
          n_fail++; $display("FAIL commit_hold cyc %0d got busy=%b pat=%h want 1/0", i, cfg_busy, patterns_out);
        end
      end
    end
    n_checks++;
    if (patterns_out !== 32'h000C_0000 || cfg_busy !== 1'b0) begin
      n_fail++; $display("FAIL commit_applied got pat=%h busy=%b want 000c0000/0", patterns_out, cfg_busy);
    end
    idle(); cfg_wr_en = 1; cfg_addr = 4'd3; cfg_data = 2'b01; cfg_commit = 1; tick(); idle();
    n_checks++;
    if (cfg_busy !== 1'b1 || patterns_out !== 32'h000C_0000) begin
      n_fail++; $display("FAIL commit_wr_same got busy=%b pat=%h want 1/000c0000", cfg_busy, patterns_out);
    end
    tick();
    n_checks++;
    if (cfg_busy !== 1'b0 || patterns_out !== 32'h000C_0040) begin
      n_fail++; $display("FAIL commit_wr_applied got busy=%b pat=%h want 0/000c0040", cfg_busy, patterns_out);
    end
  endtask

  task automatic test_counter_sat();
    int guard;
    do_reset();
    err_in_valid = 1; chk_eners = '0; chk_flags = flags_nz(16);
    guard = 0;
    while (m_cnt < 65520 && guard < 5000) begin err_in = rand_word(); tick(); guard++; end
    n_checks++;
    if (guard >= 5000 || err_event_count !== 16'd65520) begin
      n_fail++; $display("FAIL cnt_ramp got %0d want 65520 (iters %0d)", err_event_count, guard);
    end
    chk_flags = flags_nz(13); tick();
    n_checks++;
    if (err_event_count !== 16'd65533) begin n_fail++; $display("FAIL cnt_near got %0d want 65533", err_event_count); end
    chk_flags = flags_nz(5); tick();
    n_checks++;
    if (err_event_count !== 16'd65535) begin n_fail++; $display("FAIL cnt_sat got %0d want 65535", err_event_count); end
    tick();
    n_checks++;
    if (err_event_count !== 16'd65535) begin n_fail++; $display("FAIL cnt_sat_hold got %0d want 65535", err_event_count); end
    cnt_clear = 1; tick(); cnt_clear = 0;
    n_checks++;
    if (err_event_count !== 16'd0 || flags_valid !== 1'b1) begin
      n_fail++; $display("FAIL cnt_clear got %0d fv=%b want 0/1", err_event_count, flags_valid);
    end
    tick();
    n_checks++;
    if (err_event_count !== 16'd5) begin n_fail++; $display("FAIL cnt_after_clear got %0d want 5", err_event_count); end
    idle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      err_in_valid = 1; err_in = rand_word(); chk_flags = flags_nz(3);
      cfg_commit = (i == 3); tick();
    end
    cfg_commit = 0;
    n_checks++;
    if (cfg_busy !== 1'b1 || chk_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got busy=%b chk=%b want 1/1", cfg_busy, chk_valid);
    end
    rst = 1; tick(); rst = 0;
    n_checks++;
    if ({chk_valid, flags_valid, cfg_busy, err_event_count} !== 19'd0 || errstream_out !== '0 ||
        flags_out !== '0 || eners_out !== '0 || patterns_out !== '0) begin
      n_fail++; $display("FAIL mid_reset got chk=%b fv=%b busy=%b cnt=%0d want all 0", chk_valid, flags_valid, cfg_busy, err_event_count);
    end
    for (int i = 0; i < 4; i++) begin
      idle(); err_in_valid = (i == 0); err_in = rand_word(); tick();
      n_checks++;
      if (chk_valid !== 1'b0 || flags_valid !== 1'b0 || cfg_busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_reprime cyc %0d got chk=%b fv=%b busy=%b want 0/0/0", i, chk_valid, flags_valid, cfg_busy);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      err_in_valid = ($urandom_range(0, 9) < 6); err_in = rand_word();
      chk_flags = flags_nz($urandom_range(0, 16)); chk_eners = rand_eners();
      cfg_wr_en = ($urandom_range(0, 9) == 0); cfg_addr = 4'($urandom); cfg_data = 2'($urandom);
      cfg_commit = ($urandom_range(0, 19) == 0); cnt_clear = ($urandom_range(0, 29) == 0);
`ifdef TNC_SEQ_ENER_THRESH_EN
      ener_thresh = NW'($urandom_range(100, 400));
`endif
      tick();
      n_checks++;
      if (chk_valid !== m_chk || flags_valid !== m_fv || cfg_busy !== m_pend || err_event_count !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rand_ctrl cyc %0d got %b%b%b cnt=%0d want %b%b%b cnt=%0d", i, chk_valid, flags_valid, cfg_busy, err_event_count, m_chk, m_fv, m_pend, m_cnt);
      end
      n_checks++;
      if (errstream_out !== {m_cur, m_prev} || flags_out !== m_flags || eners_out !== m_eners || patterns_out !== pack_active()) begin
        n_fail++; $display("FAIL rand_data cyc %0d got flags=%h pat=%h want flags=%h pat=%h", i, flags_out, patterns_out, m_flags, pack_active());
      end
    end
    idle();
`ifdef TNC_SEQ_ENER_THRESH_EN
    ener_thresh = '1;
`endif
  endtask

`ifdef TNC_SEQ_ENER_THRESH_EN
  task automatic test_ener_thresh();
    do_reset();
    ener_thresh = 18'd100;
    err_in_valid = 1; err_in = rand_word(); tick();
    err_in = rand_word(); tick(); idle();
    chk_flags = '0; chk_eners = '0;
    chk_flags[11:0] = 12'h333;
    chk_eners[0 +: NW] = 18'd50; chk_eners[NW +: NW] = 18'd100; chk_eners[2*NW +: NW] = 18'd150;
    tick();
    n_checks++;
    if (flags_out !== 64'h3 || err_event_count !== 16'd1 || flags_valid !== 1'b1) begin
      n_fail++; $display("FAIL thresh_flags got flags=%h cnt=%0d want 3/1", flags_out, err_event_count);
    end
    n_checks++;
    if (eners_out[3*NW-1:0] !== {18'd150, 18'd100, 18'd50}) begin
      n_fail++; $display("FAIL thresh_eners got %h", eners_out[3*NW-1:0]);
    end
    ener_thresh = '1;
  endtask
`endif

  initial begin
    rst = 1; idle(); err_in = '0; chk_flags = '0; chk_eners = '0;
    cfg_addr = '0; cfg_data = '0;
`ifdef TNC_SEQ_ENER_THRESH_EN
    ener_thresh = '1;
`endif
    test_reset();
    test_stream_abc();
    test_sparse();
    test_commit();
    test_counter_sat();
    test_reset_midstream();
    test_back_to_back_random();
`ifdef TNC_SEQ_ENER_THRESH_EN
    test_ener_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trellis_neighbor_checker_seq.md
Name: trellis_neighbor_checker_seq

Overview:
- Sequencer and configuration controller for the combinational trellis neighbor checker.
- Buffers the incoming estimated-error stream into the two-word window the checker consumes, and marks when that window is valid.
- Holds double-buffered trellis patterns, committed atomically between checks.
- Registers the checker's flags and energies, and keeps a saturating count of flagged positions.

Parameters:
- width, 16: error samples per word.
- est_err_bitwidth, 9: signed error sample width.
- branch_bitwidth, 2: signed trellis branch width.
- num_of_trellis_patterns, 4: pattern count N.
- trellis_pattern_depth, 4: taps per pattern D.
- ener_bitwidth, 18: energy width.
- flag_bitwidth, 4: flag width; must be >= $clog2(2*N+1).
- cnt_bitwidth, 16: event counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- err_in  in  width*est_err_bitwidth  new error word; sample k at bits [k*est_err_bitwidth +: est_err_bitwidth].
- err_in_valid  in  1  err_in valid this cycle.
- errstream_out  out  2*width*est_err_bitwidth  checker window; samples 0..width-1 = previous word, width..2*width-1 = current word.
- chk_valid  out  1  window just updated and fully primed.
- chk_flags  in  width*flag_bitwidth  checker flags (combinational from errstream_out).
- chk_eners  in  width*ener_bitwidth  checker best energies.
- flags_out  out  width*flag_bitwidth  registered flags.
- eners_out  out  width*ener_bitwidth  registered energies.
- flags_valid  out  1  flags_out/eners_out updated this cycle.
- cfg_wr_en  in  1  shadow pattern write.
- cfg_addr  in  $clog2(N*D)  shadow pattern address; addr = pattern*D + tap.
- cfg_data  in  branch_bitwidth  branch value.
- cfg_commit  in  1  request shadow-to-active copy.
- cfg_busy  out  1  commit pending.
- patterns_out  out  N*D*branch_bitwidth  active patterns, same addr packing.
- cnt_clear  in  1  clear event counter.
- err_event_count  out  cnt_bitwidth  saturating count of nonzero flags.

Behaviour:
- Reset: all outputs, window, shadow and active patterns, and counter go to 0; FSM goes to EMPTY; pending commit is cleared. A reset mid-stream discards the window, so priming restarts.
- Window FSM: EMPTY -> HALF on accepted word; HALF -> FULL on accepted word; FULL stays FULL. No other transitions except reset.
- On each accepted word: prev <= cur, cur <= err_in.
- chk_valid: registered; 1 in the cycle after a word is accepted while the state was HALF or FULL, else 0.
- Result capture: in a cycle with chk_valid = 1, flags_out/eners_out <= chk_flags/chk_eners, and flags_valid = 1 in the next cycle.
- Latency: err_in_valid to flags_valid is 2 cycles once primed. The first two words produce one result, after the second word. Back-to-back valid words give back-to-back results.
- Config writes:
  - cfg_wr_en with cfg_addr < N*D and cfg_busy = 0 writes the shadow register.
  - Writes with an out-of-range address, or while cfg_busy = 1, are ignored.
- Commit:
  - cfg_commit sets pending, so cfg_busy = 1 the next cycle.
  - Pending applies on the first cycle with chk_valid = 0 and err_in_valid = 0; all shadow registers are copied to active in that cycle, and cfg_busy clears the next cycle.
  - cfg_commit while pending has no extra effect.
  - A commit and a write in the same cycle with cfg_busy = 0: the write lands in shadow first and is included in the commit.
- Counter:
  - When flags_valid is about to assert, err_event_count adds the number of nonzero flags in the captured word, saturating at 2^cnt_bitwidth-1.
  - cnt_clear zeroes the counter and wins over a same-cycle increment; that increment is lost.

Optional Feature:
- Macro: TNC_SEQ_ENER_THRESH_EN.
- With the macro: adds input ener_thresh (ener_bitwidth). At capture, any flag whose energy >= ener_thresh is written to flags_out as 0 and is not counted; eners_out is unchanged.
- Without the macro: the port is absent, and flags pass through unmodified.

Test Plan:
- Reset, then words A, B, C on consecutive cycles:
  - chk_valid high 2 cycles, starting after B.
  - errstream_out = {A,B} then {B,C}.
  - flags_valid follows each chk_valid by 1 cycle.
- Sparse valid (every 3rd cycle):
  - one chk_valid per word after priming.
  - window unchanged on idle cycles.
  - no spurious flags_valid.
- Write pattern 2 tap 1 = -1 (addr 9), then commit during continuous traffic:
  - patterns_out unchanged and cfg_busy = 1 until the first idle cycle.
  - the active update lands on that cycle.
  - a write attempted while busy is ignored.
- Checker returns flags with 5 nonzero per word, counter at 2^16-3:
  - count saturates at 65535.
  - cnt_clear coincident with capture yields 0.
- Assert rst in state FULL with a commit pending:
  - all outputs 0 and cfg_busy 0.
  - the next single word gives no chk_valid.
- With TNC_SEQ_ENER_THRESH_EN and ener_thresh = 100, energies {50,100,150} with flag 3:
  - flags_out = {3,0,0}.
  - count += 1.
